// File: rtl/div_issue_ctrl.sv
// Valid/ready front-end for an external combinational 32/16 divider: holds operands stable for
// HOLD_CYC cycles, then captures quotient/remainder onto a registered valid/ready output.
module div_issue_ctrl #(
    parameter int unsigned HOLD_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [15:0] in_b,
    output logic [31:0] div_a,
    output logic [15:0] div_b,
    input  logic [31:0] div_result,
    input  logic [31:0] div_odd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_quot,
    output logic [31:0] out_rem,
    output logic        out_dz,
    output logic        busy
);

    localparam logic [3:0] CntInit = 4'(HOLD_CYC - 1);

    typedef enum logic [1:0] {StIdle, StHold, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] div_a_q, div_a_d;
    logic [15:0] div_b_q, div_b_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] rem_q, rem_d;
    logic        dz_q, dz_d;
    logic        valid_q, valid_d;

    logic accept, capture, handshake, zero_div;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (in_b != '0) begin
                        state_d = StHold;
                        cnt_d   = CntInit;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Output / control decode
    always_comb begin
        in_ready  = (state_q == StIdle);
        busy      = (state_q != StIdle);
        accept    = in_ready && in_valid;
        zero_div  = (in_b == '0);
        capture   = (state_q == StHold) && (cnt_q == '0);
        handshake = (state_q == StDone) && out_ready;
    end

    // Datapath next values; operands and results only move on accept/capture
    always_comb begin
        div_a_d = div_a_q;
        div_b_d = div_b_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        valid_d = valid_q;
        if (accept) begin
            div_a_d = in_a;
            div_b_d = in_b;
            if (zero_div) begin
                // Divider output is meaningless for B=0; report a fixed encoding instead
                quot_d  = 32'hFFFF_FFFF;
                rem_d   = in_a;
                dz_d    = 1'b1;
                valid_d = 1'b1;
            end
        end
        if (capture) begin
            quot_d  = div_result;
            rem_d   = div_odd;
            dz_d    = 1'b0;
            valid_d = 1'b1;
        end
        if (handshake) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_a_q <= '0;
            div_b_q <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            div_a_q <= div_a_d;
            div_b_q <= div_b_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            valid_q <= valid_d;
        end
    end

    assign div_a     = div_a_q;
    assign div_b     = div_b_q;
    assign out_quot  = quot_q;
    assign out_rem   = rem_q;
    assign out_dz    = dz_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed and random checks of div_issue_ctrl with a scoreboard of expected results.
module tb_div_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [15:0] in_b;
    logic [31:0] div_a;
    logic [15:0] div_b;
    logic [31:0] div_result;
    logic [31:0] div_odd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_quot;
    logic [31:0] out_rem;
    logic        out_dz;
    logic        busy;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   pushed    = 0;
    int   delivered = 0;
    int   dropped   = 0;

    always #5 clk = ~clk;

    // Behavioural stand-in for the external divider
    assign div_result = (div_b == 16'd0) ? 32'hFFFF_FFFF : div_a / {16'd0, div_b};
    assign div_odd    = (div_b == 16'd0) ? div_a : div_a % {16'd0, div_b};

    div_issue_ctrl #(.HOLD_CYC(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_result(div_result),
        .div_odd   (div_odd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_quot  (out_quot),
        .out_rem   (out_rem),
        .out_dz    (out_dz),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %h, want %h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [15:0] b);
        exp_t e;
        if (b == 16'd0) begin
            e.q  = 32'hFFFF_FFFF;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            e.q  = a / 32'(b);
            e.r  = a % 32'(b);
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Inputs only change at posedge+1, so the negedge sees what the next posedge will see.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            dropped += exp_q.size();
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                chk("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    delivered++;
                    chk("sb_quot", out_quot, e.q);
                    chk("sb_rem", out_rem, e.r);
                    chk("sb_dz", 32'(out_dz), 32'(e.dz));
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_a, in_b));
                pushed++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [31:0] a, input logic [15:0] b);
        int n;
        in_a      = a;
        in_b      = b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk("req_done_in_time", 32'(out_valid), 32'd1);
        step();
        chk("req_released", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int          sent;
        int          cyc;
        int          n;
        int          r;
        logic        have_req;
        logic        acc;
        logic [31:0] ra;
        logic [15:0] rb;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        #2;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_div_a", div_a, 32'd0);
        chk("rst_div_b", 32'(div_b), 32'd0);
        chk("rst_quot", out_quot, 32'd0);
        chk("rst_rem", out_rem, 32'd0);
        chk("rst_dz", 32'(out_dz), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Normal divide: 100/7 with HOLD_CYC=2
        in_a     = 32'd100;
        in_b     = 16'd7;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t1_in_ready_T", 32'(in_ready), 32'd0);
        chk("t1_busy_T", 32'(busy), 32'd1);
        chk("t1_valid_T", 32'(out_valid), 32'd0);
        chk("t1_div_a", div_a, 32'd100);
        chk("t1_div_b", 32'(div_b), 32'd7);
        step();
        chk("t1_valid_T1", 32'(out_valid), 32'd0);
        chk("t1_in_ready_T1", 32'(in_ready), 32'd0);
        step();
        chk("t1_valid_T2", 32'(out_valid), 32'd1);
        chk("t1_quot", out_quot, 32'd14);
        chk("t1_rem", out_rem, 32'd2);
        chk("t1_dz", 32'(out_dz), 32'd0);
        chk("t1_in_ready_done", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t1_valid_after_hs", 32'(out_valid), 32'd0);
        chk("t1_in_ready_after_hs", 32'(in_ready), 32'd1);
        chk("t1_quot_retained", out_quot, 32'd14);

        // Divide by zero: result one cycle after accept
        in_a     = 32'h0000_1234;
        in_b     = 16'd0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("dz_valid", 32'(out_valid), 32'd1);
        chk("dz_quot", out_quot, 32'hFFFF_FFFF);
        chk("dz_rem", out_rem, 32'h0000_1234);
        chk("dz_flag", 32'(out_dz), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("dz_valid_after_hs", 32'(out_valid), 32'd0);
        chk("dz_in_ready_after_hs", 32'(in_ready), 32'd1);

        // Backpressure with a second request waiting
        in_a     = 32'h40;
        in_b     = 16'd8;
        in_valid = 1'b1;
        step();
        in_a = 32'd5;
        in_b = 16'd1;
        step();
        step();
        chk("bp_valid_start", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_quot", out_quot, 32'd8);
            chk("bp_rem", out_rem, 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_div_a", div_a, 32'h40);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_in_ready_after_hs", 32'(in_ready), 32'd1);
        chk("bp_valid_after_hs", 32'(out_valid), 32'd0);
        step();
        in_valid = 1'b0;
        chk("bp_second_accept_a", div_a, 32'd5);
        chk("bp_second_accept_b", 32'(div_b), 32'd1);
        chk("bp_second_busy", 32'(busy), 32'd1);
        step();
        step();
        chk("bp_second_valid", 32'(out_valid), 32'd1);
        chk("bp_second_quot", out_quot, 32'd5);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Extremes
        do_req(32'hFFFF_FFFF, 16'hFFFF);
        chk("ext1_quot", out_quot, 32'h0001_0001);
        chk("ext1_rem", out_rem, 32'd0);
        do_req(32'hDEAD_BEEF, 16'd1);
        chk("ext2_quot", out_quot, 32'hDEAD_BEEF);
        chk("ext2_rem", out_rem, 32'd0);
        out_ready = 1'b0;

        // Reset during HOLD abandons the request
        in_a     = 32'd1000;
        in_b     = 16'd3;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("rh_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rh_in_ready_async", 32'(in_ready), 32'd1);
        chk("rh_valid_async", 32'(out_valid), 32'd0);
        chk("rh_div_a_async", div_a, 32'd0);
        chk("rh_quot_async", out_quot, 32'd0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rh_no_valid", 32'(out_valid), 32'd0);
            chk("rh_in_ready", 32'(in_ready), 32'd1);
            chk("rh_rem", out_rem, 32'd0);
        end
        chk("rh_dropped", 32'(dropped), 32'd1);

        // Random traffic with random backpressure
        sent     = 0;
        cyc      = 0;
        have_req = 1'b0;
        ra       = '0;
        rb       = '0;
        while (sent < 100 && cyc < 4000) begin
            if (!have_req) begin
                r  = int'($urandom_range(0, 9));
                ra = $urandom;
                if (r == 0) rb = 16'd0;
                else if (r == 1) rb = 16'hFFFF;
                else rb = 16'($urandom);
                have_req = 1'b1;
            end
            in_a      = ra;
            in_b      = rb;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            acc       = in_valid && in_ready;
            step();
            cyc++;
            if (acc) begin
                sent++;
                have_req = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (busy && n < 50) begin
            step();
            n++;
        end
        chk("rnd_idle", 32'(busy), 32'd0);
        chk("rnd_sent", 32'(sent), 32'd100);
        chk("rnd_sb_drained", 32'(exp_q.size()), 32'd0);
        chk("rnd_delivered", 32'(delivered), 32'(pushed - dropped));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
